// File: rtl/serin_rx.sv
// serin_rx: POKEY serial-input receiver; synchronizes SID, frames start/8 data/stop bits
// on bitTick and delivers the byte to SERIN with status pulses for SKSTAT and IRQ.
module serin_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       skRst,
  input  logic       asyncMode,
  input  logic       bitTick,
  input  logic       sid,
  input  logic       serinRd,
  output logic       siDelay,
  output logic       sdiBusy,
  output logic       sdiOvrun,
  output logic       setFramer,
  output logic       serinIrq,
  output logic       timerReset,
  output logic [7:0] serinDout
);
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_e;
  state_e state_q, state_d;
  logic [1:0] sync_q;
  logic       prev_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, dout_q, dout_d;
  logic       pend_q, pend_d;
  logic       irq_q, irq_d, fr_q, fr_d, ovr_q, ovr_d, tr_q, tr_d;
  logic       fall, start, done;
  assign fall  = prev_q & ~sync_q[1];
  assign start = asyncMode ? fall : bitTick & ~sync_q[1];
  assign done  = ~skRst & (state_q == STOP) & bitTick;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= 3'd0;
      sh_q    <= 8'h00;
      dout_q  <= 8'h00;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
      fr_q    <= 1'b0;
      ovr_q   <= 1'b0;
      tr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], sid};
      prev_q  <= sync_q[1];
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      fr_q    <= fr_d;
      ovr_q   <= ovr_d;
      tr_q    <= tr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (skRst) state_d = IDLE;
    else if (state_q == IDLE && start) state_d = DATA;
    else if (state_q == DATA && bitTick && cnt_q == 3'd7) state_d = STOP;
    else if (done) state_d = IDLE;
  end
  // a read in the completion cycle is applied before the new byte sets pending
  always_comb begin
    cnt_d  = (skRst || state_q == IDLE) ? 3'd0 : (state_q == DATA && bitTick) ? cnt_q + 3'd1 : cnt_q;
    sh_d   = skRst ? 8'h00 : (state_q == DATA && bitTick) ? {sync_q[1], sh_q[7:1]} : sh_q;
    dout_d = done ? sh_q : dout_q;
    pend_d = ~skRst & (done | (pend_q & ~serinRd));
    irq_d  = done;
    fr_d   = done & ~sync_q[1];
    ovr_d  = done & pend_q & ~serinRd;
    tr_d   = ~skRst & (state_q == IDLE) & asyncMode & fall;
  end
  assign siDelay    = sync_q[1];
  assign sdiBusy    = state_q != IDLE;
  assign sdiOvrun   = ovr_q;
  assign setFramer  = fr_q;
  assign serinIrq   = irq_q;
  assign timerReset = tr_q;
  assign serinDout  = dout_q;
endmodule

// File: tb/tb_serin_rx.sv
// tb_serin_rx: table-driven and randomized frame checks for serin_rx against a frame-level model.
module tb_serin_rx;
  logic       clk = 1'b0;
  logic       reset, skRst, asyncMode, bitTick, sid, serinRd;
  logic       siDelay, sdiBusy, sdiOvrun, setFramer, serinIrq, timerReset;
  logic [7:0] serinDout;
  int tests = 0, fails = 0;
  int n_irq, n_fr, n_ovr, n_tr, n_busy, n_both;
  logic       mp;
  logic [7:0] md;
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       rdb;
    logic       rde;
    logic       efr;
    logic       eovr;
  } vec_t;
  vec_t tv[8];
  serin_rx dut (
    .clk(clk), .reset(reset), .skRst(skRst), .asyncMode(asyncMode), .bitTick(bitTick),
    .sid(sid), .serinRd(serinRd), .siDelay(siDelay), .sdiBusy(sdiBusy), .sdiOvrun(sdiOvrun),
    .setFramer(setFramer), .serinIrq(serinIrq), .timerReset(timerReset), .serinDout(serinDout)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic clr();
    n_irq = 0; n_fr = 0; n_ovr = 0; n_tr = 0; n_busy = 0; n_both = 0;
  endtask
  // advance one clock and tally what the DUT shows just after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
    n_irq += int'(serinIrq);
    n_fr += int'(setFramer);
    n_ovr += int'(sdiOvrun);
    n_tr += int'(timerReset);
    n_busy += int'(sdiBusy);
    n_both += int'(serinIrq && setFramer);
  endtask
  task automatic send_bit(input logic b, input int gap, input logic rd);
    sid = b;
    repeat (gap) cyc();
    bitTick = 1'b1;
    serinRd = rd;
    cyc();
    bitTick = 1'b0;
    serinRd = 1'b0;
  endtask
  task automatic send_data(input logic [7:0] d, input logic stop, input logic rde, input int gap, output int busy);
    busy = 0;
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i], gap, 1'b0);
      busy += gap + 1;
    end
    send_bit(stop, gap, rde);
    busy += gap + 1;
  endtask
  task automatic run_frame(input logic [7:0] d, input logic stop, input logic rdb, input logic rde,
                           input int gap, input logic efr, input logic eovr);
    int busy;
    if (rdb) begin
      serinRd = 1'b1;
      cyc();
      serinRd = 1'b0;
    end
    clr();
    send_bit(1'b0, gap, 1'b0);
    send_data(d, stop, rde, gap, busy);
    sid = 1'b1;
    repeat (3) cyc();
    check("frame_dout", serinDout, d);
    check("frame_irq", n_irq, 1);
    check("frame_framer", n_fr, efr);
    check("frame_ovrun", n_ovr, eovr);
    check("frame_irq_framer_same", n_both, efr);
    check("frame_busy_cycles", n_busy, busy);
    check("frame_no_timer_reset", n_tr, 0);
  endtask
  initial begin
    int b1, b2;
    tv[0] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{8'hC3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[2] = '{8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[3] = '{8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[4] = '{8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[5] = '{8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[7] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    reset = 1'b1; skRst = 1'b0; asyncMode = 1'b0; bitTick = 1'b0; sid = 1'b1; serinRd = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    clr();
    cyc();
    check("rst_dout", serinDout, 8'h00);
    check("rst_sidelay", siDelay, 1'b1);
    check("rst_busy", sdiBusy, 1'b0);
    check("rst_pulses", {serinIrq, setFramer, sdiOvrun, timerReset}, 4'b0000);
    mp = 1'b0;
    md = 8'h00;
    sid = 1'b0;
    cyc();
    check("sync_lat1", siDelay, 1'b1);
    cyc();
    check("sync_lat2", siDelay, 1'b0);
    sid = 1'b1;
    repeat (3) cyc();
    bitTick = 1'b1;
    cyc();
    bitTick = 1'b0;
    check("idle_tick_mark_ignored", sdiBusy, 1'b0);
    for (int i = 0; i < 8; i++) run_frame(tv[i].data, tv[i].stop, tv[i].rdb, tv[i].rde, 15, tv[i].efr, tv[i].eovr);
    mp = 1'b1;
    md = 8'hFF;
    serinRd = 1'b1;
    cyc();
    serinRd = 1'b0;
    clr();
    send_bit(1'b0, 15, 1'b0);
    send_data(8'h5A, 1'b1, 1'b0, 15, b1);
    send_bit(1'b0, 15, 1'b0);
    send_data(8'h3C, 1'b1, 1'b0, 15, b2);
    sid = 1'b1;
    repeat (3) cyc();
    check("b2b_dout", serinDout, 8'h3C);
    check("b2b_irq", n_irq, 2);
    check("b2b_ovrun", n_ovr, 1);
    check("b2b_busy", n_busy, b1 + b2);
    md = 8'h3C;
    asyncMode = 1'b1;
    repeat (5) cyc();
    clr();
    sid = 1'b0;
    cyc();
    check("async_tr_c1", timerReset, 1'b0);
    cyc();
    check("async_tr_c2", timerReset, 1'b0);
    cyc();
    check("async_tr_c3", timerReset, 1'b1);
    check("async_busy", sdiBusy, 1'b1);
    repeat (7) cyc();
    send_data(8'hA5, 1'b1, 1'b0, 15, b1);
    sid = 1'b1;
    repeat (3) cyc();
    check("async_dout", serinDout, 8'hA5);
    check("async_irq", n_irq, 1);
    check("async_tr_count", n_tr, 1);
    check("async_ovrun", n_ovr, mp);
    mp = 1'b1;
    md = 8'hA5;
    asyncMode = 1'b0;
    repeat (3) cyc();
    clr();
    send_bit(1'b0, 15, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 15, 1'b0);
    skRst = 1'b1;
    cyc();
    check("skrst_busy", sdiBusy, 1'b0);
    sid = 1'b0;
    repeat (3) cyc();
    bitTick = 1'b1;
    cyc();
    bitTick = 1'b0;
    check("skrst_holds_idle", sdiBusy, 1'b0);
    check("skrst_no_pulses", n_irq + n_fr + n_ovr + n_tr, 0);
    check("skrst_dout_kept", serinDout, md);
    sid = 1'b1;
    repeat (3) cyc();
    skRst = 1'b0;
    mp = 1'b0;
    run_frame(8'h01, 1'b1, 1'b0, 1'b0, 15, 1'b0, 1'b0);
    mp = 1'b1;
    md = 8'h01;
    clr();
    send_bit(1'b0, 15, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 15, 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("reset_abort_busy", sdiBusy, 1'b0);
    cyc();
    check("reset_abort_dout", serinDout, 8'h00);
    check("reset_abort_pulses", n_irq + n_fr + n_ovr + n_tr, 0);
    mp = 1'b0;
    md = 8'h00;
    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic stop, rdb, rde;
      int gap;
      d = 8'($urandom);
      stop = $urandom_range(0, 3) != 0;
      rdb = 1'($urandom_range(0, 1));
      rde = 1'($urandom_range(0, 1));
      gap = $urandom_range(2, 12);
      if (rdb) mp = 1'b0;
      run_frame(d, stop, rdb, rde, gap, !stop, mp && !rde);
      mp = 1'b1;
      md = d;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
